// File: rtl/calc_seq.sv
// Signed add/sub/mul/div sequencer: add/sub and divide-by-zero complete in one cycle,
// mul and div iterate for W cycles on operand magnitudes and apply the signs at the end.
module calc_seq #(
    parameter int W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     op,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*W-1:0] result,
    output logic [W-1:0]   rem,
    output logic           dbz,
    output logic           out_valid,
    input  logic           out_ready
);
    // state | meaning
    // IDLE  | waiting for a request (in_ready=1)
    // EXEC  | W-cycle shift/add multiply or restoring divide in progress
    // DONE  | result held until the consumer takes it (out_valid=1)
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam int CW = $clog2(W + 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           is_mul, neg_q, neg_r;
    logic [W-1:0]   mag_b, part, shift_q;
    logic [W-1:0]   part_nxt, shift_nxt;
    logic [W:0]     sum, s_div;
    logic           ge;
    logic           accept, fast_op, last_step;
    logic [2*W-1:0] mag_out, final_result, ext_a, ext_b;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign fast_op   = !op[1] || (op[0] && (b == '0));
    assign last_step = (state == EXEC) && (cnt == CW'(1));
    assign ext_a     = {{W{a[W-1]}}, a};
    assign ext_b     = {{W{b[W-1]}}, b};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = fast_op ? DONE : EXEC;
            EXEC: if (last_step) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: part:shift_q is the product (mul) or remainder:dividend (div)
    always_comb begin
        sum       = {1'b0, part} + (shift_q[0] ? {1'b0, mag_b} : '0);
        s_div     = {part, shift_q[W-1]};
        ge        = s_div >= {1'b0, mag_b};
        part_nxt  = '0;
        shift_nxt = '0;
        if (is_mul) begin
            part_nxt  = sum[W:1];
            shift_nxt = {sum[0], shift_q[W-1:1]};
        end else begin
            part_nxt  = ge ? (s_div[W-1:0] - mag_b) : s_div[W-1:0];
            shift_nxt = {shift_q[W-2:0], ge};
        end
        mag_out      = is_mul ? {part_nxt, shift_nxt} : {{W{1'b0}}, shift_nxt};
        final_result = neg_q ? -mag_out : mag_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            result  <= '0;
            rem     <= '0;
            dbz     <= 1'b0;
            is_mul  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            mag_b   <= '0;
            part    <= '0;
            shift_q <= '0;
        end else if (accept) begin
            rem <= '0;
            dbz <= 1'b0;
            case (op)
                2'b00: result <= ext_a + ext_b;
                2'b01: result <= ext_a - ext_b;
                default: begin
                    if (op[0] && (b == '0)) begin
                        result <= '0;
                        dbz    <= 1'b1;
                    end else begin
                        cnt     <= CW'(W);
                        is_mul  <= !op[0];
                        neg_q   <= a[W-1] ^ b[W-1];
                        neg_r   <= a[W-1];
                        mag_b   <= mag(b);
                        part    <= '0;
                        shift_q <= mag(a);
                    end
                end
            endcase
        end else if (state == EXEC) begin
            cnt     <= cnt - CW'(1);
            part    <= part_nxt;
            shift_q <= shift_nxt;
            if (last_step) begin
                result <= final_result;
                rem    <= is_mul ? '0 : (neg_r ? -part_nxt : part_nxt);
            end
        end
    end
endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 Parameter: W, default 5, operand width in bits (W >= 2).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: a  input  W  signed operand A.
REQ-005 Port: b  input  W  signed operand B.
REQ-006 Port: op  input  2  operation: 00 add, 01 sub (A-B), 10 mul, 11 div (A/B).
REQ-007 Port: in_valid  input  1  request valid.
REQ-008 Port: in_ready  output  1  block can accept a request.
REQ-009 Port: result  output  2W  signed result, sign-extended to 2W.
REQ-010 Port: rem  output  W  signed division remainder; 0 for non-div ops.
REQ-011 Port: dbz  output  1  division-by-zero flag for the current result.
REQ-012 Port: out_valid  output  1  result/rem/dbz valid.
REQ-013 Port: out_ready  input  1  consumer accepts result.

Function
REQ-014 States SHALL be IDLE, EXEC, DONE.
REQ-015 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-016 Accept: at a rising edge with in_valid=1 and in_ready=1, the block SHALL capture a, b and op; inputs are ignored at all other times.
REQ-017 Add/sub accept: IDLE->DONE directly; out_valid SHALL rise 1 cycle after the accept edge.
REQ-018 Div with b=0 accept: IDLE->DONE directly, result=0, rem=0, dbz=1; latency 1 cycle.
REQ-019 Mul or div with b!=0 accept: IDLE->EXEC; an iteration counter runs exactly W cycles; EXEC->DONE on the W-th edge; out_valid rises W+1 cycles after the accept edge.
REQ-020 Add/sub: operands sign-extended to 2W before the operation; the result is exact (no overflow possible).
REQ-021 Mul: exact signed 2W-bit product, including (-2^(W-1))*(-2^(W-1)) = +2^(2W-2).
REQ-022 Div: quotient truncated toward zero, rem = A - q*B (sign of A, |rem| < |B|); quotient sign-extended into result.
REQ-023 Div (-2^(W-1))/(-1) SHALL give +2^(W-1) in result (fits 2W), rem=0.
REQ-024 dbz SHALL be 0 for every result other than div-by-zero.
REQ-025 DONE: result, rem, dbz and out_valid SHALL be held stable while out_ready=0 (no limit on stall length).
REQ-026 DONE->IDLE at the edge with out_valid=1 and out_ready=1; outputs result/rem/dbz MAY keep their last values in IDLE, but out_valid SHALL be 0.
REQ-027 Back-to-back: a new request can be accepted at the earliest 1 cycle after the output handshake edge (minimum 2 cycles between accepts for add/sub).
REQ-028 Operand changes on a/b/op while in EXEC or DONE SHALL NOT affect the result in flight.

Reset
REQ-029 At a rising edge with rst_n=0: state=IDLE, counter=0, result=0, rem=0, dbz=0, out_valid=0; in_ready=1 from the first edge after rst_n returns to 1.
REQ-030 rst_n has priority over every handshake; a reset during EXEC or DONE discards the operation with no output handshake.
REQ-031 in_valid asserted in the same cycle as rst_n=0 SHALL NOT be accepted.

Verification (W=5)
REQ-032 add 8+7, out_ready=1 -> out_valid 1 cycle after accept, result=15, rem=0, dbz=0; sub -8-(-4) -> -4.
REQ-033 mul -6*2 -> result=-12 (10'h3F4), out_valid exactly 6 cycles after accept; mul -16*-16 -> 256.
REQ-034 div -7/2 -> result=-3, rem=-1; div 8/4 -> 2, rem 0; div -16/-1 -> 16; each with latency 6 cycles.
REQ-035 div 7/0 -> result=0, rem=0, dbz=1 after 1 cycle; the next add 1+1 -> dbz=0, result=2.
REQ-036 Hold out_ready=0 for 10 cycles after mul 4*3 -> out_valid and result=12 stable, in_ready=0 throughout; in_valid pulses during the stall are ignored.
REQ-037 Assert rst_n=0 for 1 cycle on the 3rd EXEC cycle of div 15/4 -> no out_valid, in_ready=1 one cycle after release, the next add 2+3 returns 5.
